// File: rtl/motoro3_ramp_ctrl.sv
// Command sequencer in front of motoro3_top: linear speed ramping, forced ramp-down and coast
// before stop or direction reversal. Optional e-stop input/fault output via MOTORO3_ESTOP_EN.
module motoro3_ramp_ctrl #(
  parameter int unsigned FREQ_MIN  = 1000,
  parameter int unsigned FREQ_MAX  = 1023,
  parameter int unsigned FREQ_STEP = 1,
  parameter int unsigned STEP_DIV  = 10000,
  parameter int unsigned STOP_HOLD = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_run,
  input  logic       cmd_dir,
  input  logic [9:0] cmd_freq,
`ifdef MOTORO3_ESTOP_EN
  input  logic       estop,
  output logic       fault,
`endif
  output logic       m3start,
  output logic       m3invOrStop,
  output logic [9:0] m3freq,
  output logic       busy,
  output logic [2:0] state_o
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_UP   = 3'd1,
    ST_RUN  = 3'd2,
    ST_DOWN = 3'd3,
    ST_STOP = 3'd4,
    ST_HOLD = 3'd5
  } state_e;

  // One counter serves both the ramp tick and the coast hold, so size it for the longer one.
  localparam int unsigned CNT_MAX = (STEP_DIV > STOP_HOLD) ? STEP_DIV : STOP_HOLD;
  localparam int unsigned CW = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] TICK_LAST = CW'(STEP_DIV - 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(STOP_HOLD - 1);
  localparam logic [9:0]  FMIN10 = 10'(FREQ_MIN);
  localparam logic [9:0]  FMAX10 = 10'(FREQ_MAX);
  localparam logic [9:0]  STEP10 = 10'(FREQ_STEP);
  localparam logic [10:0] STEP11 = 11'(FREQ_STEP);

  function automatic logic [9:0] clampFreq(input logic [9:0] f);
    logic [9:0] r;
    r = f;
    if (f < FMIN10) r = FMIN10;
    if (f > FMAX10) r = FMAX10;
    return r;
  endfunction

  // Ramp steps are evaluated one bit wider so a step near the top cannot wrap past the target.
  function automatic logic [9:0] stepUp(input logic [9:0] cur, input logic [9:0] tgt);
    logic [10:0] sum;
    sum = {1'b0, cur} + STEP11;
    return (sum >= {1'b0, tgt}) ? tgt : sum[9:0];
  endfunction

  function automatic logic [9:0] stepDown(input logic [9:0] cur, input logic [9:0] floorVal);
    return ({1'b0, cur} <= ({1'b0, floorVal} + STEP11)) ? floorVal : (cur - STEP10);
  endfunction

  state_e          state_q, state_d;
  logic [9:0]      cur_q, cur_d;
  logic [9:0]      tgt_q, tgt_d;
  logic            dir_q, dir_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            pendRun_q, pendRun_d;
  logic            pendDir_q, pendDir_d;
  logic [9:0]      pendTgt_q, pendTgt_d;
  logic            m3start_q, m3start_d;
  logic            ready_q, ready_d;
  logic            busy_q, busy_d;
  logic            accept;
  logic            tick;
  logic [9:0]      reqTgt;
`ifdef MOTORO3_ESTOP_EN
  logic            fault_q, fault_d;
`endif

  assign accept = cmd_valid & cmd_ready;
  assign tick   = (cnt_q == TICK_LAST);
  assign reqTgt = clampFreq(cmd_freq);

  always_comb begin
    state_d   = state_q;
    cur_d     = cur_q;
    tgt_d     = tgt_q;
    dir_d     = dir_q;
    cnt_d     = cnt_q;
    pendRun_d = pendRun_q;
    pendDir_d = pendDir_q;
    pendTgt_d = pendTgt_q;
`ifdef MOTORO3_ESTOP_EN
    fault_d   = fault_q;
`endif

    case (state_q)
      ST_IDLE: begin
        cur_d = FMIN10;
        if (accept && cmd_run) begin
          dir_d   = cmd_dir;
          tgt_d   = reqTgt;
          cnt_d   = '0;
          state_d = ST_UP;
        end
      end

      ST_UP, ST_RUN, ST_DOWN: begin
        // A new command always beats a ramp tick landing in the same cycle.
        if (accept) begin
          cnt_d = '0;
          if (cmd_run && (cmd_dir == dir_q)) begin
            tgt_d = reqTgt;
            if (reqTgt > cur_q)      state_d = ST_UP;
            else if (reqTgt < cur_q) state_d = ST_DOWN;
            else                     state_d = ST_RUN;
          end else begin
            pendRun_d = cmd_run;
            pendDir_d = cmd_dir;
            pendTgt_d = reqTgt;
            state_d   = ST_STOP;
          end
        end else if (state_q == ST_RUN) begin
          cnt_d = '0;
        end else if (tick) begin
          cnt_d = '0;
          cur_d = (state_q == ST_UP) ? stepUp(cur_q, tgt_q) : stepDown(cur_q, tgt_q);
          if (cur_d == tgt_q) state_d = ST_RUN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_STOP: begin
        if (cur_q == FMIN10) begin
          cnt_d   = '0;
          state_d = ST_HOLD;
        end else if (tick) begin
          cnt_d = '0;
          cur_d = stepDown(cur_q, FMIN10);
          if (cur_d == FMIN10) state_d = ST_HOLD;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_HOLD: begin
        cur_d = FMIN10;
        if (cnt_q == HOLD_LAST) begin
          cnt_d     = '0;
          pendRun_d = 1'b0;
          pendDir_d = 1'b0;
          pendTgt_d = FMIN10;
          if (pendRun_q) begin
            dir_d   = pendDir_q;
            tgt_d   = pendTgt_q;
            state_d = ST_UP;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        cnt_d   = '0;
        cur_d   = FMIN10;
        state_d = ST_IDLE;
      end
    endcase

`ifdef MOTORO3_ESTOP_EN
    // Only run=0 commands get through while faulted; accepting one acknowledges the fault.
    if (accept && fault_q) fault_d = 1'b0;
    if (estop) begin
      state_d   = ST_HOLD;
      cur_d     = FMIN10;
      tgt_d     = tgt_q;
      dir_d     = dir_q;
      cnt_d     = '0;
      pendRun_d = 1'b0;
      fault_d   = 1'b1;
    end
`endif

    m3start_d = (state_d == ST_UP) || (state_d == ST_RUN) ||
                (state_d == ST_DOWN) || (state_d == ST_STOP);
    ready_d   = (state_d == ST_IDLE) || (state_d == ST_UP) ||
                (state_d == ST_RUN) || (state_d == ST_DOWN);
`ifdef MOTORO3_ESTOP_EN
    ready_d   = ready_d | fault_d;
`endif
    busy_d    = !((state_d == ST_IDLE) || (state_d == ST_RUN));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cur_q     <= FMIN10;
      tgt_q     <= FMIN10;
      dir_q     <= 1'b0;
      cnt_q     <= '0;
      pendRun_q <= 1'b0;
      pendDir_q <= 1'b0;
      pendTgt_q <= FMIN10;
      m3start_q <= 1'b0;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
`ifdef MOTORO3_ESTOP_EN
      fault_q   <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cur_q     <= cur_d;
      tgt_q     <= tgt_d;
      dir_q     <= dir_d;
      cnt_q     <= cnt_d;
      pendRun_q <= pendRun_d;
      pendDir_q <= pendDir_d;
      pendTgt_q <= pendTgt_d;
      m3start_q <= m3start_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
`ifdef MOTORO3_ESTOP_EN
      fault_q   <= fault_d;
`endif
    end
  end

  assign m3start     = m3start_q;
  assign m3invOrStop = dir_q;
  assign m3freq      = cur_q;
  assign busy        = busy_q;
  assign state_o     = state_q;
`ifdef MOTORO3_ESTOP_EN
  assign fault       = fault_q;
  assign cmd_ready   = ready_q & ~(fault_q & cmd_run);
`else
  assign cmd_ready   = ready_q;
`endif

endmodule

// File: tb/tb_motoro3_ramp_ctrl.sv
// Self-checking bench for motoro3_ramp_ctrl: directed scenarios plus random commands checked
// every cycle against a time-based behavioural model. Honours MOTORO3_ESTOP_EN when defined.
module tb_motoro3_ramp_ctrl;

  localparam int FMIN  = 1000;
  localparam int FMAX  = 1023;
  localparam int FSTEP = 1;
  localparam int SDIV  = 4;
  localparam int SHOLD = 8;

  localparam int IDLE_M = 0;
  localparam int UP_M   = 1;
  localparam int RUN_M  = 2;
  localparam int DOWN_M = 3;
  localparam int STOP_M = 4;
  localparam int HOLD_M = 5;

  logic       clk;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_run;
  logic       cmd_dir;
  logic [9:0] cmd_freq;
  logic       m3start;
  logic       m3invOrStop;
  logic [9:0] m3freq;
  logic       busy;
  logic [2:0] state_o;
`ifdef MOTORO3_ESTOP_EN
  logic       estop;
  logic       fault;
`endif

  int checks = 0;
  int errors = 0;

  // Model state: phase, speed, target, direction, time of last phase entry/step, pending command.
  int now = 0;
  int mMode = IDLE_M;
  int mCur = FMIN;
  int mTgt = FMIN;
  int mDir = 0;
  int mMark = 0;
  int mPendRun = 0;
  int mPendDir = 0;
  int mPendTgt = FMIN;
  int mFault = 0;

  motoro3_ramp_ctrl #(
    .FREQ_MIN(FMIN), .FREQ_MAX(FMAX), .FREQ_STEP(FSTEP), .STEP_DIV(SDIV), .STOP_HOLD(SHOLD)
  ) dut (
    .clk(clk),
    .rst(rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_run(cmd_run),
    .cmd_dir(cmd_dir),
    .cmd_freq(cmd_freq),
`ifdef MOTORO3_ESTOP_EN
    .estop(estop),
    .fault(fault),
`endif
    .m3start(m3start),
    .m3invOrStop(m3invOrStop),
    .m3freq(m3freq),
    .busy(busy),
    .state_o(state_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    if (observed != expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%0d expected=%0d at t=%0t", tag, observed, expected, $time);
    end
  endtask

  function automatic int modelReady(input bit run);
    int r;
    r = (mMode == IDLE_M || mMode == UP_M || mMode == RUN_M || mMode == DOWN_M) ? 1 : 0;
`ifdef MOTORO3_ESTOP_EN
    if (mFault != 0) r = run ? 0 : 1;
`else
    if (run && !run) r = 0;
`endif
    return r;
  endfunction

  task automatic enterMode(input int m);
    mMode = m;
    mMark = now;
  endtask

  // Advances the model by one clock edge using the inputs present at that edge.
  task automatic modelEdge(input bit v, input bit r, input bit d, input int f, input bit rs, input bit es);
    bit acc;
    int t;
    bit due;
    now++;
    if (rs) begin
      mMode = IDLE_M; mCur = FMIN; mTgt = FMIN; mDir = 0; mMark = now;
      mPendRun = 0; mPendDir = 0; mPendTgt = FMIN; mFault = 0;
      return;
    end
    acc = v && (modelReady(r) != 0);
    t = (f < FMIN) ? FMIN : ((f > FMAX) ? FMAX : f);
    if (es) begin
      enterMode(HOLD_M);
      mCur = FMIN;
      mPendRun = 0;
      mFault = 1;
      return;
    end
    if (acc && mFault != 0) mFault = 0;
    due = ((now - mMark) == SDIV);
    if (mMode == IDLE_M) begin
      if (acc && r) begin
        mDir = d; mTgt = t;
        enterMode(UP_M);
      end
    end else if (mMode == UP_M || mMode == RUN_M || mMode == DOWN_M) begin
      if (acc) begin
        if (r && (d == mDir[0])) begin
          mTgt = t;
          enterMode(t > mCur ? UP_M : (t < mCur ? DOWN_M : RUN_M));
        end else begin
          mPendRun = r; mPendDir = d; mPendTgt = t;
          enterMode(STOP_M);
        end
      end else if (due && mMode != RUN_M) begin
        if (mMode == UP_M) mCur = (mCur + FSTEP > mTgt) ? mTgt : mCur + FSTEP;
        else               mCur = (mCur - FSTEP < mTgt) ? mTgt : mCur - FSTEP;
        mMark = now;
        if (mCur == mTgt) mMode = RUN_M;
      end
    end else if (mMode == STOP_M) begin
      if (mCur == FMIN) begin
        enterMode(HOLD_M);
      end else if (due) begin
        mCur = (mCur - FSTEP < FMIN) ? FMIN : mCur - FSTEP;
        mMark = now;
        if (mCur == FMIN) mMode = HOLD_M;
      end
    end else if (mMode == HOLD_M) begin
      if ((now - mMark) == SHOLD) begin
        if (mPendRun != 0) begin
          mDir = mPendDir; mTgt = mPendTgt;
          enterMode(UP_M);
        end else begin
          enterMode(IDLE_M);
        end
        mPendRun = 0; mPendDir = 0; mPendTgt = FMIN;
      end
    end
  endtask

  task automatic applyStimulus(input bit v, input bit r, input bit d, input int f, input bit rs, input bit es);
    cmd_valid = v;
    cmd_run   = r;
    cmd_dir   = d;
    cmd_freq  = 10'(f);
    rst       = rs;
`ifdef MOTORO3_ESTOP_EN
    estop     = es;
`endif
    @(posedge clk);
    modelEdge(v, r, d, f, rs, es);
    #1;
    checkOutput("state", int'(state_o), mMode);
    checkOutput("m3freq", int'(m3freq), mCur);
    checkOutput("m3start", int'(m3start), (mMode >= UP_M && mMode <= STOP_M) ? 1 : 0);
    checkOutput("m3invOrStop", int'(m3invOrStop), mDir);
    checkOutput("busy", int'(busy), (mMode == IDLE_M || mMode == RUN_M) ? 0 : 1);
    checkOutput("cmd_ready", int'(cmd_ready), modelReady(cmd_run));
`ifdef MOTORO3_ESTOP_EN
    checkOutput("fault", int'(fault), mFault);
`endif
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_state"}, int'(state_o), IDLE_M);
    checkOutput({tag, "_m3start"}, int'(m3start), 0);
    checkOutput({tag, "_m3freq"}, int'(m3freq), FMIN);
    checkOutput({tag, "_ready"}, int'(cmd_ready), 1);
    checkOutput({tag, "_busy"}, int'(busy), 0);
    checkOutput({tag, "_inv"}, int'(m3invOrStop), 0);
  endtask

  initial begin
    cmd_valid = 1'b0; cmd_run = 1'b0; cmd_dir = 1'b0; cmd_freq = '0; rst = 1'b1;
`ifdef MOTORO3_ESTOP_EN
    estop = 1'b0;
`endif
    applyStimulus(1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b0);
    checkResetValues("rst");

    // Start from IDLE and ramp to 1010, one step per four clocks.
    applyStimulus(1'b1, 1'b1, 1'b0, 1010, 1'b0, 1'b0);
    checkOutput("t1_start", int'(m3start), 1);
    checkOutput("t1_busy", int'(busy), 1);
    idleCycles(39);
    checkOutput("t1_state39", int'(state_o), UP_M);
    checkOutput("t1_freq39", int'(m3freq), 1009);
    idleCycles(1);
    checkOutput("t1_state40", int'(state_o), RUN_M);
    checkOutput("t1_freq40", int'(m3freq), 1010);
    checkOutput("t1_idle_busy", int'(busy), 0);

    // Direction reversal: ramp down, coast, re-accelerate the other way.
    applyStimulus(1'b1, 1'b1, 1'b1, 1005, 1'b0, 1'b0);
    checkOutput("t3_stop", int'(state_o), STOP_M);
    checkOutput("t3_ready", int'(cmd_ready), 0);
    idleCycles(39);
    checkOutput("t3_freq39", int'(m3freq), 1001);
    checkOutput("t3_start39", int'(m3start), 1);
    idleCycles(1);
    checkOutput("t3_hold", int'(state_o), HOLD_M);
    checkOutput("t3_hold_start", int'(m3start), 0);
    checkOutput("t3_hold_inv", int'(m3invOrStop), 0);
    idleCycles(7);
    checkOutput("t3_hold7", int'(state_o), HOLD_M);
    idleCycles(1);
    checkOutput("t3_up", int'(state_o), UP_M);
    checkOutput("t3_up_inv", int'(m3invOrStop), 1);
    idleCycles(20);
    checkOutput("t3_run", int'(state_o), RUN_M);
    checkOutput("t3_run_freq", int'(m3freq), 1005);

    // Retarget to the top, then down to 1015 without overshoot.
    applyStimulus(1'b1, 1'b1, 1'b1, 1023, 1'b0, 1'b0);
    idleCycles(72);
    checkOutput("t2_top_state", int'(state_o), RUN_M);
    checkOutput("t2_top_freq", int'(m3freq), 1023);
    applyStimulus(1'b1, 1'b1, 1'b1, 1015, 1'b0, 1'b0);
    checkOutput("t2_down", int'(state_o), DOWN_M);
    idleCycles(31);
    checkOutput("t2_down_freq", int'(m3freq), 1016);
    idleCycles(1);
    checkOutput("t2_down_state", int'(state_o), RUN_M);
    checkOutput("t2_down_end", int'(m3freq), 1015);
    applyStimulus(1'b1, 1'b0, 1'b1, 1000, 1'b0, 1'b0);
    idleCycles(70);
    checkOutput("t2_idle", int'(state_o), IDLE_M);

    // Stop during UP at 1004; commands offered in HOLD are ignored.
    applyStimulus(1'b1, 1'b1, 1'b0, 1010, 1'b0, 1'b0);
    idleCycles(16);
    checkOutput("t4_up_freq", int'(m3freq), 1004);
    applyStimulus(1'b1, 1'b0, 1'b0, 1010, 1'b0, 1'b0);
    checkOutput("t4_stop", int'(state_o), STOP_M);
    idleCycles(15);
    checkOutput("t4_stop_freq", int'(m3freq), 1001);
    idleCycles(1);
    checkOutput("t4_hold", int'(state_o), HOLD_M);
    for (int i = 0; i < 7; i++) applyStimulus(1'b1, 1'b1, 1'b0, 1010, 1'b0, 1'b0);
    checkOutput("t4_hold_kept", int'(state_o), HOLD_M);
    idleCycles(1);
    checkOutput("t4_idle", int'(state_o), IDLE_M);
    checkOutput("t4_idle_start", int'(m3start), 0);

    // Target below FREQ_MIN clamps; UP exits on the first tick.
    applyStimulus(1'b1, 1'b1, 1'b0, 900, 1'b0, 1'b0);
    checkOutput("t2_clamp_up", int'(state_o), UP_M);
    idleCycles(3);
    checkOutput("t2_clamp_wait", int'(state_o), UP_M);
    idleCycles(1);
    checkOutput("t2_clamp_run", int'(state_o), RUN_M);
    checkOutput("t2_clamp_freq", int'(m3freq), 1000);

    // STOP entered already at FREQ_MIN goes straight to HOLD.
    applyStimulus(1'b1, 1'b0, 1'b0, 1000, 1'b0, 1'b0);
    checkOutput("bnd_stop", int'(state_o), STOP_M);
    idleCycles(1);
    checkOutput("bnd_hold", int'(state_o), HOLD_M);
    idleCycles(8);
    checkOutput("bnd_idle", int'(state_o), IDLE_M);

    // Reset in the middle of STOP.
    applyStimulus(1'b1, 1'b1, 1'b1, 1012, 1'b0, 1'b0);
    idleCycles(40);
    checkOutput("t5_freq", int'(m3freq), 1010);
    applyStimulus(1'b1, 1'b0, 1'b0, 1000, 1'b0, 1'b0);
    idleCycles(5);
    checkOutput("t5_stop", int'(state_o), STOP_M);
    applyStimulus(1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b0);
    checkResetValues("t5_rst");

`ifdef MOTORO3_ESTOP_EN
    applyStimulus(1'b1, 1'b1, 1'b0, 1003, 1'b0, 1'b0);
    idleCycles(12);
    checkOutput("t6_run", int'(state_o), RUN_M);
    applyStimulus(1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b1);
    checkOutput("t6_start", int'(m3start), 0);
    checkOutput("t6_fault", int'(fault), 1);
    checkOutput("t6_hold", int'(state_o), HOLD_M);
    applyStimulus(1'b1, 1'b1, 1'b0, 1010, 1'b0, 1'b0);
    checkOutput("t6_runheld", int'(cmd_ready), 0);
    checkOutput("t6_fault_kept", int'(fault), 1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1000, 1'b0, 1'b0);
    checkOutput("t6_fault_clr", int'(fault), 0);
    idleCycles(10);
    checkOutput("t6_idle", int'(state_o), IDLE_M);
`endif

    // Random command traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      bit v;
      bit r;
      bit d;
      bit rs;
      bit es;
      int f;
      v  = ($urandom_range(0, 29) == 0);
      r  = ($urandom_range(0, 4) != 0);
      d  = ($urandom_range(0, 3) == 0) ? (mDir == 0) : (mDir != 0);
      case ($urandom_range(0, 7))
        0:       f = $urandom_range(0, 1023);
        1:       f = mCur;
        default: f = $urandom_range(990, 1023);
      endcase
      rs = ($urandom_range(0, 1999) == 0);
      es = 1'b0;
`ifdef MOTORO3_ESTOP_EN
      es = ($urandom_range(0, 799) == 0);
`endif
      applyStimulus(v, r, d, f, rs, es);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/motoro3_ramp_ctrl.md
Name: motoro3_ramp_ctrl

Overview:
Command sequencer in front of motoro3_top.
- Accepts run/direction/speed commands over a valid/ready handshake.
- Drives m3start, m3invOrStop and m3freq with a linear speed ramp.
- Direction reversal and stop are forced through ramp-down to FREQ_MIN, then a coast hold with m3start low, then re-acceleration.
- Prevents abrupt speed steps and hot direction changes at the 3-phase bridge.

Parameters:
FREQ_MIN, 1000, lowest speed code; ramp start/end point; matches motoro3_top input clamp
FREQ_MAX, 1023, highest speed code; targets above are clamped
FREQ_STEP, 1, speed-code increment/decrement per ramp tick
STEP_DIV, 10000, clk cycles per ramp tick (1 ms at 10 MHz)
STOP_HOLD, 50000, clk cycles of coast with m3start=0 before re-start or idle

Ports:
clk  in  1  system clock, 10 MHz
rst  in  1  synchronous reset, active-high
cmd_valid  in  1  command present
cmd_ready  out  1  command accepted when cmd_valid & cmd_ready at posedge clk
cmd_run  in  1  1=run, 0=stop
cmd_dir  in  1  requested direction
cmd_freq  in  10  target speed code
m3start  out  1  to motoro3_top m3start
m3invOrStop  out  1  to motoro3_top m3invOrStop (active direction)
m3freq  out  10  to motoro3_top m3freq (current ramp value)
busy  out  1  1 in any state except IDLE and RUN
state_o  out  3  encoded state: IDLE=0, UP=1, RUN=2, DOWN=3, STOP=4, HOLD=5

Behaviour:
- Reset: single clock, synchronous active-high; all flops update on posedge clk only.
- Reset values: state=IDLE, m3start=0, m3invOrStop=0, m3freq=FREQ_MIN, cmd_ready=1, busy=0, tick counter=0, pending cmd cleared.
- rst asserted mid-ramp returns to IDLE the next edge; no ramp-down.
- All outputs are registered.
- Target clamp on accept: tgt = min(max(cmd_freq, FREQ_MIN), FREQ_MAX).
- Ramp arithmetic: 11-bit internal; cur±FREQ_STEP is saturated to tgt, never overshoots.
- Tick counter: resets to 0 on every state entry and on every ramp step. A tick fires when count==STEP_DIV-1.
- cmd_ready=1 in IDLE, UP, RUN, DOWN; 0 in STOP and HOLD.
- IDLE:
  - Outputs m3start=0, m3freq=FREQ_MIN.
  - Accept with run=1: dir_r=cmd_dir, tgt latched, then UP. Next cycle m3start=1, m3invOrStop=dir_r.
  - Accept with run=0: no effect.
- UP: cur += FREQ_STEP each tick. cur==tgt goes to RUN, in the same cycle as the final step.
- DOWN (running, slowing to a new lower tgt): cur -= FREQ_STEP each tick. cur==tgt goes to RUN.
- RUN: holds cur; m3start=1.
- Accept in UP, RUN or DOWN:
  - run=1, dir==dir_r: retarget. tgt>cur goes to UP, tgt<cur to DOWN, equal to RUN. The tick counter restarts.
  - run=0, or dir!=dir_r: store pending {run, dir, tgt}, then STOP.
- STOP: cur -= FREQ_STEP each tick down to FREQ_MIN. Then HOLD. m3start stays 1 throughout STOP.
- HOLD:
  - m3start=0, m3freq=FREQ_MIN, m3invOrStop holds old dir_r.
  - After STOP_HOLD cycles: pending run=1 loads dir_r/tgt and goes to UP; otherwise IDLE. Pending is cleared.
- Boundary cases:
  - tgt==FREQ_MIN accepted in IDLE: UP exits to RUN on the first tick.
  - Accept and tick in the same cycle: the accept wins and the step is discarded.
  - STOP entered with cur==FREQ_MIN: goes to HOLD on the next edge.

Optional Feature:
MOTORO3_ESTOP_EN
- Enabled: adds input estop (1 bit) and output fault (1 bit, reset 0).
- estop high in any state: next edge m3start=0, m3freq=FREQ_MIN, fault=1, state=HOLD, pending forced to run=0.
- While fault=1: cmd_ready=1, but only run=0 commands are accepted. Such an accept clears fault; run=1 commands are held off with cmd_ready=0.
- Disabled: no estop/fault ports, no fault logic.

Test Plan:
Bench params: FREQ_MIN=1000, FREQ_MAX=1023, FREQ_STEP=1, STEP_DIV=4, STOP_HOLD=8.
1. Reset then start: accept {run=1, dir=0, freq=1010} -> m3start=1 next cycle; m3freq +1 every 4 clks; RUN at 1010 after 40 clks; busy=0.
2. Clamp: accept freq=900 -> RUN at 1000 on the first tick. Accept freq=1023 then ramp retarget to 1015 from RUN -> DOWN to 1015, no overshoot.
3. Reversal: in RUN at 1010, accept {1, dir=1, 1005}. Required sequence:
   - STOP ramps 1010→1000, cmd_ready=0.
   - HOLD 8 clks with m3start=0, m3invOrStop=0.
   - UP with m3invOrStop=1 to 1005.
4. Stop command during UP at 1004 -> ramp down to 1000, HOLD 8 clks, IDLE, m3start=0. A cmd_valid during HOLD is not accepted.
5. rst pulsed mid-STOP -> next edge IDLE, all outputs at reset values.
6. MOTORO3_ESTOP_EN: estop in RUN -> m3start=0 next clk, fault=1. {run=1} held off. {run=0} accept clears fault; IDLE after HOLD.
